tff_counter_311: RTL and testbench
==================================

TFF_COUNTER_311 -- requirements
Module: tff_counter_311

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..8.
REQ-002 Parameter MODULUS, default 10: count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 clk_311  input  1  single clock; all state updates on the falling edge of clk_311.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the falling edge of clk_311.
REQ-005 en_311  input  1  count enable; one step per enabled edge.
REQ-006 up_311  input  1  direction; 1 = up, 0 = down.
REQ-007 load_311  input  1  synchronous parallel load of d_311.
REQ-008 d_311  input  WIDTH  load value.
REQ-009 q_311  output  WIDTH  registered count.
REQ-010 t_311  output  WIDTH  combinational toggle vector, one bit per stage, for driving downstream T flip-flop stages.
REQ-011 tc_311  output  1  combinational terminal-count flag.
REQ-012 wrap_311  output  8  registered wrap-event counter.

Function
REQ-013 Per-edge priority SHALL be: reset low > load_311 > en_311 > hold.
REQ-014 Load: q_311 SHALL take d_311 when d_311 < MODULUS, otherwise 0; wrap_311 unchanged.
REQ-015 Up count (en_311=1, up_311=1): q_311 SHALL increment by 1; at MODULUS-1 it SHALL wrap to 0.
REQ-016 Down count (en_311=1, up_311=0): q_311 SHALL decrement by 1; at 0 it SHALL wrap to MODULUS-1.
REQ-017 Hold (en_311=0, load_311=0): q_311 and wrap_311 SHALL hold.
REQ-018 Define next = the value q_311 takes at the coming edge under REQ-013..017 (reset excluded); t_311 SHALL equal q_311 XOR next.
REQ-019 t_311 SHALL be all-zero whenever next equals q_311.
REQ-020 tc_311 SHALL be 1 iff en_311=1, load_311=0, and q_311 is at the wrap point for the current direction (MODULUS-1 up, 0 down).
REQ-021 Each edge that performs a wrap SHALL increment wrap_311 by 1, saturating at 255.
REQ-022 A direction change SHALL take effect on the same edge as the count; there SHALL be no turnaround cycle.
REQ-023 Latency: q_311 updates on the edge that samples the controls; t_311 and tc_311 have zero latency.
REQ-024 Load asserted together with en_311 SHALL load only; tc_311 SHALL be 0 and no wrap SHALL be counted.

Reset
REQ-025 A falling edge with reset=0 SHALL set q_311=0 and wrap_311=0, overriding load_311 and en_311.
REQ-026 During reset, t_311 SHALL follow REQ-018 using the non-reset next value.
REQ-027 Reset asserted mid-count SHALL take effect on the first sampling edge, with no partial update.
REQ-028 With reset deasserted and load_311=en_311=0, q_311 SHALL stay 0 and t_311 SHALL be all-zero.

Configuration
REQ-029 Macro TFF_COUNTER_WRAPCNT_EN defined: the wrap_311 register and its behaviour per REQ-021 SHALL be present.
REQ-030 Macro TFF_COUNTER_WRAPCNT_EN undefined: wrap_311 SHALL be tied to 0, with no register inferred; all other behaviour unchanged.

Verification
REQ-031 Scenario: reset=0 for 2 edges, then up-count 12 edges (WIDTH=4, MODULUS=10) -> q_311 sequence 1..9,0,1,2; wrap_311=1; tc_311=1 only while q_311=9.
REQ-032 Scenario: q_311=0, up_311=0, en_311=1, one edge -> q_311=9, t_311=4'b1001 before the edge, tc_311=1 before the edge.
REQ-033 Scenario: load_311=1 with d_311=7 and en_311=1 -> q_311=7, no wrap counted; then load d_311=12 -> q_311=0.
REQ-034 Scenario: at q_311=3, counting up, drive reset=0 on the next edge -> q_311=0 and wrap_311=0 on that edge.
REQ-035 Scenario: 300 wraps with the macro defined -> wrap_311=255; same stimulus with the macro undefined -> wrap_311=0 throughout.
REQ-036 Scenario: for every step, a reference T flip-flop chain driven by t_311 -> matches q_311 on each edge.

Source files
------------

// File: rtl/tff_counter_311.sv
// rtl/tff_counter_311.sv - modulo up/down counter with T-stage toggle vector, falling-edge state
// Optional wrap-event counter enabled by macro TFF_COUNTER_WRAPCNT_EN.
module tff_counter_311 #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk_311,
    input  logic             reset,
    input  logic             en_311,
    input  logic             up_311,
    input  logic             load_311,
    input  logic [WIDTH-1:0] d_311,
    output logic [WIDTH-1:0] q_311,
    output logic [WIDTH-1:0] t_311,
    output logic             tc_311,
    output logic [7:0]       wrap_311
);

    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] next_q;
    logic             at_top;
    logic             at_bot;
    logic             d_ok;
    logic             wrap_evt;

    assign at_top = (q_311 == TOP);
    assign at_bot = (q_311 == '0);
    assign d_ok   = ({1'b0, d_311} < MOD_EXT);

    // next_q ignores reset so t_311 keeps describing the counting path during reset
    always_comb begin
        next_q   = q_311;
        wrap_evt = 1'b0;
        if (load_311) begin
            next_q = d_ok ? d_311 : '0;
        end else if (en_311) begin
            if (up_311) begin
                if (at_top) begin
                    next_q   = '0;
                    wrap_evt = 1'b1;
                end else begin
                    next_q = q_311 + WIDTH'(1);
                end
            end else begin
                if (at_bot) begin
                    next_q   = TOP;
                    wrap_evt = 1'b1;
                end else begin
                    next_q = q_311 - WIDTH'(1);
                end
            end
        end
    end

    assign t_311  = q_311 ^ next_q;
    assign tc_311 = wrap_evt;

    always_ff @(negedge clk_311) begin
        if (!reset) begin
            q_311 <= '0;
        end else begin
            q_311 <= next_q;
        end
    end

`ifdef TFF_COUNTER_WRAPCNT_EN
    logic [7:0] wrap_cnt;

    always_ff @(negedge clk_311) begin
        if (!reset) begin
            wrap_cnt <= '0;
        end else if (wrap_evt && (wrap_cnt != 8'hFF)) begin
            wrap_cnt <= wrap_cnt + 8'd1;
        end
    end

    assign wrap_311 = wrap_cnt;
`else
    assign wrap_311 = '0;
`endif

endmodule

// File: tb/tb_tff_counter_311.sv
// tb/tb_tff_counter_311.sv - scoreboard bench for tff_counter_311 with modulo-arithmetic reference
module tb_tff_counter_311;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk_311 = 1'b0;
    logic         reset = 1'b0;
    logic         en_311 = 1'b0;
    logic         up_311 = 1'b0;
    logic         load_311 = 1'b0;
    logic [W-1:0] d_311 = '0;
    logic [W-1:0] q_311;
    logic [W-1:0] t_311;
    logic         tc_311;
    logic [7:0]   wrap_311;

    tff_counter_311 #(.WIDTH(W), .MODULUS(M)) dut (
        .clk_311 (clk_311),
        .reset   (reset),
        .en_311  (en_311),
        .up_311  (up_311),
        .load_311(load_311),
        .d_311   (d_311),
        .q_311   (q_311),
        .t_311   (t_311),
        .tc_311  (tc_311),
        .wrap_311(wrap_311)
    );

    always #5 clk_311 = ~clk_311;

    typedef struct {
        logic         rst;
        logic         chk;
        logic [W-1:0] t;
        logic         tc;
        logic [W-1:0] q;
        logic [7:0]   w;
    } exp_s;

    exp_s exp_q[$];
    int   tests = 0;
    int   fails = 0;

    int   m_q = 0;
    int   m_w = 0;
    bit   known = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one edge's controls and push what the counter must show for it
    task automatic step(input bit rst, input bit ld, input bit en, input bit up, input int d);
        exp_s e;
        int   nq;
        bit   wev;
        @(posedge clk_311);
        #1;
        reset    = rst;
        load_311 = ld;
        en_311   = en;
        up_311   = up;
        d_311    = W'(d);
        if (ld)      nq = (d < M) ? d : 0;
        else if (en) nq = up ? (m_q + 1) % M : (m_q + M - 1) % M;
        else         nq = m_q;
        wev   = !ld && en && (up ? (m_q == M - 1) : (m_q == 0));
        e.rst = !rst;
        e.chk = known;
        e.t   = W'(m_q ^ nq);
        e.tc  = wev;
        if (!rst) begin
            m_q   = 0;
            m_w   = 0;
            known = 1;
        end else begin
            m_q = nq;
`ifdef TFF_COUNTER_WRAPCNT_EN
            if (wev && m_w < 255) m_w++;
`endif
        end
        e.q = W'(m_q);
        e.w = 8'(m_w);
        exp_q.push_back(e);
    endtask

    // Monitor: comb outputs before the falling edge, registered ones after it
    logic [W-1:0] chain = '0;
    initial begin
        exp_s         e;
        logic [W-1:0] t_cap;
        logic         tc_cap;
        forever begin
            @(posedge clk_311);
            #3;
            if (exp_q.size() == 0) continue;
            t_cap  = t_311;
            tc_cap = tc_311;
            @(negedge clk_311);
            #1;
            e = exp_q.pop_front();
            if (e.chk) begin
                check("t_311", int'(t_cap), int'(e.t));
                check("tc_311", int'(tc_cap), int'(e.tc));
            end
            check("q_311", int'(q_311), int'(e.q));
            check("wrap_311", int'(wrap_311), int'(e.w));
            if (e.rst) begin
                chain = '0;
            end else if (e.chk) begin
                chain = chain ^ t_cap;
                check("tff_chain", int'(chain), int'(e.q));
            end
        end
    end

    initial begin
        int r;
        // reset two edges then count up through one wrap
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 5);
        for (int i = 0; i < 12; i++) step(1, 0, 1, 1, 0);
        // hold after reset
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        // down from 0 wraps to top
        step(1, 0, 1, 0, 0);
        // load with enable, then out-of-range load
        step(1, 1, 1, 1, 7);
        step(1, 1, 0, 0, 12);
        step(1, 1, 1, 0, 9);
        step(1, 1, 1, 1, 15);
        // reset mid-count at 3
        step(1, 1, 0, 0, 3);
        step(0, 1, 1, 1, 8);
        step(1, 0, 1, 1, 0);
        // direction change without turnaround
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, 63));
            step(r != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
        end
        // 300 wraps for saturation
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 300 * M; i++) step(1, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_311);
        repeat (2) @(posedge clk_311);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
